// File: rtl/sll_iter_shifter.sv
// ---------------------------------------------------------------------------
// sll_iter_shifter
//   Multicycle logical-left shifter. It shifts an operand left by 0..WIDTH-1
//   bits, one bit per clock, and zero-fills bit 0. Its start/ready handshake
//   matches the multdiv unit: a ctrl_start pulse goes in and a
//   data_resultRDY pulse comes out.
//
// Ports
//   clock          : rising-edge clock
//   reset          : asynchronous, active-high; returns to IDLE and clears
//                    all state
//   ctrl_start     : request, sampled only in IDLE or DONE
//   data_operandA  : value to shift, captured together with ctrl_start
//   ctrl_shamt     : shift amount, captured together with ctrl_start
//   data_result    : shifted value; final while data_resultRDY=1 and held
//                    until the next accepted start
//   data_resultRDY : one-cycle pulse (state DONE)
//   data_busy      : high while shifting (state SHIFT)
//   data_lost      : sticky per operation; set if any 1 left bit WIDTH-1
//
// Timing
//   ctrl_start sampled at edge E0 -> SHIFT
//   edges E0+1 .. E0+shamt        -> one bit shifted at each edge
//   edge  E0+shamt+1              -> DONE, so RDY is high in the next cycle
// ---------------------------------------------------------------------------
module sll_iter_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_start,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [SHW-1:0]   ctrl_shamt,
    output logic [WIDTH-1:0] data_result,
    output logic             data_resultRDY,
    output logic             data_busy,
    output logic             data_lost
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] result;
    logic [SHW-1:0]   cnt;
    logic             lost;

    // The counter only counts down. It is tested for zero before each
    // decrement, so it never wraps.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            result <= '0;
            cnt    <= '0;
            lost   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ctrl_start) begin
                        result <= data_operandA;
                        cnt    <= ctrl_shamt;
                        lost   <= 1'b0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    // ctrl_start and the operand inputs are ignored here.
                    if (cnt != '0) begin
                        result <= {result[WIDTH-2:0], 1'b0};
                        cnt    <= cnt - SHW'(1);
                        lost   <= lost | result[WIDTH-1];
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // A start in DONE loads the next operation and skips the
                    // IDLE turnaround (back-to-back operation).
                    if (ctrl_start) begin
                        result <= data_operandA;
                        cnt    <= ctrl_shamt;
                        lost   <= 1'b0;
                        state  <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign data_result    = result;
    assign data_lost      = lost;
    assign data_busy      = (state == SHIFT);
    assign data_resultRDY = (state == DONE);

endmodule

// File: tb/tb_sll_iter_shifter.sv
// ---------------------------------------------------------------------------
// tb_sll_iter_shifter
//   Self-checking bench for sll_iter_shifter. It runs:
//   - a table of directed operations,
//   - randomized operations checked against an arithmetic reference
//     (a 64-bit shift: the low half is the result, and the high half is
//     non-zero exactly when a 1 bit was shifted out),
//   - hand-written sequences for reset mid-shift, back-to-back starts and a
//     start ignored during SHIFT.
// Outputs are sampled 1 time unit after the rising edge. Inputs are driven on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_sll_iter_shifter;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic             clock;
    logic             reset;
    logic             ctrl_start;
    logic [WIDTH-1:0] data_operandA;
    logic [SHW-1:0]   ctrl_shamt;
    logic [WIDTH-1:0] data_result;
    logic             data_resultRDY;
    logic             data_busy;
    logic             data_lost;

    int tests = 0;
    int fails = 0;

    sll_iter_shifter #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_start     (ctrl_start),
        .data_operandA  (data_operandA),
        .ctrl_shamt     (ctrl_shamt),
        .data_result    (data_result),
        .data_resultRDY (data_resultRDY),
        .data_busy      (data_busy),
        .data_lost      (data_lost)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [WIDTH-1:0] op;
        logic [SHW-1:0]   shamt;
        logic [WIDTH-1:0] exp_res;
        logic             exp_lost;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: a plain 64-bit arithmetic shift.
    task automatic model(input logic [WIDTH-1:0] op, input logic [SHW-1:0] sh,
                         output logic [WIDTH-1:0] res, output logic lost);
        logic [63:0] wide;
        wide = {32'd0, op} << sh;
        res  = wide[31:0];
        lost = |wide[63:32];
    endtask

    // Starts one operation and waits (bounded) for RDY. Then it checks the
    // latency, the number of busy cycles, the result and lost bit, and that
    // all of these hold after DONE.
    task automatic run_op(input string name, input logic [WIDTH-1:0] op,
                          input logic [SHW-1:0] sh,
                          input logic [WIDTH-1:0] exp_res, input logic exp_lost);
        int n;
        int busy_n;
        @(negedge clock);
        ctrl_start    = 1'b1;
        data_operandA = op;
        ctrl_shamt    = sh;
        @(posedge clock); #1;
        ctrl_start    = 1'b0;
        data_operandA = $urandom;           // must not affect the operation
        ctrl_shamt    = SHW'($urandom);
        n      = 0;
        busy_n = 0;
        while (!data_resultRDY && n < 40) begin
            if (data_busy) busy_n++;
            @(posedge clock); #1;
            n++;
        end
        chk({name, " latency"}, n, sh + 1);
        chk({name, " busy cycles"}, busy_n, sh + 1);
        chk({name, " result"}, data_result, exp_res);
        chk({name, " lost"}, {31'd0, data_lost}, {31'd0, exp_lost});
        @(posedge clock); #1;
        chk({name, " rdy one cycle"}, {31'd0, data_resultRDY}, 32'd0);
        chk({name, " result held"}, data_result, exp_res);
        chk({name, " lost held"}, {31'd0, data_lost}, {31'd0, exp_lost});
        chk({name, " idle not busy"}, {31'd0, data_busy}, 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        logic [WIDTH-1:0] r_op, e_res;
        logic [SHW-1:0]   r_sh;
        logic             e_lost;
        int               n, rdy_n;

        reset         = 1'b1;
        ctrl_start    = 1'b0;
        data_operandA = '0;
        ctrl_shamt    = '0;
        #1;
        chk("reset result", data_result, 32'd0);
        chk("reset rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("reset busy", {31'd0, data_busy}, 32'd0);
        chk("reset lost", {31'd0, data_lost}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Directed table.
        vecs[0] = '{32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0};
        vecs[1] = '{32'hC000_0003, 5'd2,  32'h0000_000C, 1'b1};
        vecs[2] = '{32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0};
        vecs[3] = '{32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 1'b1};
        vecs[4] = '{32'h8000_0000, 5'd1,  32'h0000_0000, 1'b1};
        vecs[5] = '{32'h7FFF_FFFF, 5'd1,  32'hFFFF_FFFE, 1'b0};
        for (int i = 0; i < 6; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].shamt,
                   vecs[i].exp_res, vecs[i].exp_lost);

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            r_op = $urandom;
            r_sh = SHW'($urandom_range(0, WIDTH-1));
            model(r_op, r_sh, e_res, e_lost);
            run_op($sformatf("rand%0d", i), r_op, r_sh, e_res, e_lost);
        end

        // Reset mid-SHIFT.
        @(negedge clock);
        ctrl_start = 1'b1; data_operandA = 32'hFFFF_FFFF; ctrl_shamt = 5'd20;
        @(negedge clock);
        ctrl_start = 1'b0;
        repeat (4) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("midreset result", data_result, 32'd0);
        chk("midreset busy", {31'd0, data_busy}, 32'd0);
        chk("midreset rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("midreset lost", {31'd0, data_lost}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        rdy_n = 0;
        n     = 0;
        repeat (25) begin
            @(posedge clock); #1;
            if (data_resultRDY) rdy_n++;
            if (data_busy) n++;
        end
        chk("post-reset spurious rdy", rdy_n, 0);
        chk("post-reset busy", n, 0);

        // Back-to-back: start is held high through the whole first operation.
        // The second operation is presented while the shifter is in DONE.
        @(negedge clock);
        ctrl_start = 1'b1; data_operandA = 32'h0000_00FF; ctrl_shamt = 5'd4;
        @(posedge clock); #1;
        n = 0;
        while (!data_resultRDY && n < 40) begin
            @(posedge clock); #1;
            n++;
        end
        chk("b2b first latency", n, 5);
        chk("b2b first result", data_result, 32'h0000_0FF0);
        data_operandA = 32'h0000_0001; ctrl_shamt = 5'd1;   // start still high
        @(posedge clock); #1;
        chk("b2b no idle busy", {31'd0, data_busy}, 32'd1);
        chk("b2b no idle rdy", {31'd0, data_resultRDY}, 32'd0);
        ctrl_start = 1'b0;
        n = 0;
        while (!data_resultRDY && n < 40) begin
            @(posedge clock); #1;
            n++;
        end
        chk("b2b second latency", n, 2);
        chk("b2b second result", data_result, 32'h0000_0002);
        chk("b2b second lost", {31'd0, data_lost}, 32'd0);

        // A start during SHIFT is ignored and not queued.
        @(negedge clock);
        ctrl_start = 1'b1; data_operandA = 32'h0000_00F0; ctrl_shamt = 5'd6;
        @(negedge clock);
        ctrl_start = 1'b0;
        @(negedge clock);
        ctrl_start = 1'b1; data_operandA = 32'hFFFF_FFFF; ctrl_shamt = 5'd1;
        @(negedge clock);
        ctrl_start = 1'b0;
        rdy_n = 0;
        e_res = '0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clock); #1;
            if (data_resultRDY) begin
                rdy_n++;
                e_res = data_result;
            end
        end
        chk("ignored start rdy count", rdy_n, 1);
        chk("ignored start result", e_res, 32'h0000_3C00);
        chk("ignored start lost", {31'd0, data_lost}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
